mem_byte_loader: RTL
====================

Name: mem_byte_loader

Overview:
- Upstream fill stage for the 8-byte sequential-read memory path.
- Accepts a byte stream on a valid/ready handshake and writes it into an internal DEPTH x DATA_W array in address order 0..DEPTH-1.
- Reports completion, byte count and an 8-bit additive checksum.
- Exposes a registered read port that the downstream sequential reader scans once load_done is high.

Parameters:
DATA_W, 8, width of each stored word and of in_data/rd_data
DEPTH, 8, number of entries; must equal 2**ADDR_W
ADDR_W, 3, width of rd_addr and of the internal write pointer

Ports:
clk  input  1  clock, all state updates on posedge
reset  input  1  synchronous, active-high
start  input  1  pulse: begin a new load (honoured in IDLE and DONE only)
abort  input  1  pulse: cancel load in progress
in_valid  input  1  upstream has a byte on in_data
in_data  input  DATA_W  byte to store
in_ready  output  1  loader can accept; high only in LOAD state
load_done  output  1  high while in DONE state
byte_count  output  ADDR_W+1  bytes accepted in current/last load (0..DEPTH)
checksum  output  8  sum of accepted bytes (low 8 bits), mod 256
rd_addr  input  ADDR_W  read address from downstream reader
rd_data  output  DATA_W  registered read data

Behaviour:
- Reset (synchronous, active-high; clock clk):
  - state=IDLE, write pointer=0, byte_count=0, checksum=0, rd_data=0, in_ready=0, load_done=0.
  - Array contents untouched unless MEM_LOADER_CLR_EN is defined.
  - Reset mid-load: same as above. Already-written entries are retained.
- States: IDLE, LOAD, DONE. in_ready=(state==LOAD); load_done=(state==DONE). Both are decoded from the registered state only, with no combinational path from inputs.
- IDLE:
  - start=1: next state LOAD; write pointer, byte_count and checksum cleared to 0.
  - abort: ignored.
- LOAD:
  - A transfer occurs on a cycle with in_valid=1 and in_ready=1. On that cycle: mem[wr_ptr]<=in_data, wr_ptr<=wr_ptr+1 (wraps to 0 after DEPTH-1), byte_count<=byte_count+1, checksum<=checksum+in_data[7:0] (carry discarded).
  - When the transfer brings byte_count to DEPTH: next state DONE. in_ready drops on the following cycle, so at most DEPTH bytes are accepted.
  - abort=1: next state IDLE. A transfer in the same cycle is discarded (no write, no count/checksum update); abort wins. byte_count and checksum hold their pre-abort values.
  - start: ignored in LOAD.
  - in_valid=0: no change; any number of idle cycles allowed.
- DONE:
  - Holds byte_count=DEPTH and the final checksum.
  - start=1: clears pointer/count/checksum, next state LOAD.
  - abort: ignored.
  - start and abort asserted together in DONE: start wins.
- First acceptance is possible at the earliest on the cycle after start, because in_ready is registered-state based.
- Read port:
  - rd_data<=mem[rd_addr] every posedge, in every state; latency 1 cycle.
  - Same-cycle write and read of the same address returns the OLD contents (read-before-write).
- Arithmetic: byte_count is ADDR_W+1 bits and never exceeds DEPTH. checksum is always an 8-bit modular sum.

Optional Feature:
Macro name: MEM_LOADER_CLR_EN.
- Defined:
  - Reset zeroes all DEPTH entries in the reset cycle.
  - Every accepted start zeroes all entries in the same cycle it clears the counters.
  - Unwritten entries therefore read 0 after a partial or aborted load.
  - A read in the clearing cycle returns the pre-clear value.
- Undefined:
  - The array is never bulk-cleared. Unwritten entries keep prior contents, and are X after power-up in simulation.

Test Plan:
- Reset, start, then 8 back-to-back transfers 0x01..0x08 with in_valid held high -> in_ready high for exactly 8 cycles, load_done=1 next cycle, byte_count=8, checksum=0x24; rd_addr 0..7 returns 0x01..0x08 one cycle after each address.
- Same load with in_valid toggling 1/0 each cycle -> 8 writes in 15 cycles, identical memory contents and checksum 0x24, in_ready never asserted in IDLE/DONE.
- Load bytes 0xFF,0xFF,0x03 then abort coincident with a 4th valid byte 0x55 -> state IDLE, byte_count=3, checksum=0x01 (wrapped), mem[3] not written, load_done=0.
- From DONE, start a second load of 0xA0..0xA7 while reading rd_addr=0 on the cycle of the first write -> rd_data shows the old 0x01 that cycle and 0xA0 the next; final checksum=0x1C.
- Assert reset after 5 of 8 bytes -> all outputs at reset values next cycle; with MEM_LOADER_CLR_EN all entries read 0x00, without it entries 0..4 retain the loaded bytes.
- start and in_valid asserted together in IDLE with in_data=0x77 -> byte not accepted (in_ready=0 that cycle), byte_count stays 0 until the next valid cycle in LOAD.

Source files
------------

// File: rtl/mem_byte_loader.sv
// Purpose : fill stage that writes an upstream byte stream into a DEPTH x DATA_W array in address order.
// Latency : a byte is stored on the cycle it is accepted; rd_data is valid one cycle after rd_addr.
// Backpr. : in_ready is high only in LOAD and depends on registered state only; it drops after DEPTH bytes.
//
// Ports:
//   clk, reset      clock and synchronous active-high reset
//   start, abort    begin a load (IDLE/DONE only, start wins over abort) / cancel a load in progress
//   in_valid/in_ready/in_data   byte stream handshake into the array
//   load_done, byte_count, checksum   completion flag, accepted byte count, 8-bit modular sum
//   rd_addr, rd_data                  registered read port, read-before-write
//
// Build option: define MEM_LOADER_CLR_EN to zero the whole array on reset and on every accepted start.
// DATA_W must be at least 8, because the checksum sums the low byte of each word.

module mem_byte_loader #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 8,
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              load_done,
    output logic [ADDR_W:0]   byte_count,
    output logic [7:0]        checksum,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } state_t;

    // Count value at which the next accepted byte completes the load.
    localparam int              LAST_I   = DEPTH - 1;
    localparam logic [ADDR_W:0] LAST_CNT = LAST_I[ADDR_W:0];

    state_t            state;
    state_t            state_nxt;
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W:0]   cnt_q;
    logic [7:0]        sum_q;
    logic [DATA_W-1:0] mem [DEPTH];

    logic xfer;
    logic clr;

    // Abort beats a coincident transfer: nothing of that byte is recorded.
    assign xfer = (state == LOAD) && in_valid && !abort;
    // An accepted start; ignored while a load is running.
    assign clr  = (state != LOAD) && start;

    assign in_ready   = (state == LOAD);
    assign load_done  = (state == DONE);
    assign byte_count = cnt_q;
    assign checksum   = sum_q;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (start) state_nxt = LOAD;
            end
            LOAD: begin
                if (abort)
                    state_nxt = IDLE;
                else if (xfer && (cnt_q == LAST_CNT))
                    state_nxt = DONE;
            end
            DONE: begin
                if (start) state_nxt = LOAD;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            wr_ptr <= '0;
            cnt_q  <= '0;
            sum_q  <= '0;
        end else begin
            state <= state_nxt;
            if (clr) begin
                wr_ptr <= '0;
                cnt_q  <= '0;
                sum_q  <= '0;
            end else if (xfer) begin
                // DEPTH == 2**ADDR_W, so the pointer wraps by natural overflow.
                wr_ptr <= wr_ptr + 1'b1;
                cnt_q  <= cnt_q + 1'b1;
                sum_q  <= sum_q + in_data[7:0];
            end
        end
    end

`ifdef MEM_LOADER_CLR_EN
    always_ff @(posedge clk) begin
        if (reset || clr) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (xfer) begin
            mem[wr_ptr] <= in_data;
        end
    end
`else
    // No bulk clear: entries not rewritten keep whatever they held before.
    always_ff @(posedge clk) begin
        if (!reset && xfer) mem[wr_ptr] <= in_data;
    end
`endif

    // Non-blocking read of the array gives the pre-write (and pre-clear) contents.
    always_ff @(posedge clk) begin
        if (reset) rd_data <= '0;
        else       rd_data <= mem[rd_addr];
    end

endmodule
